demux18_scan_ctrl: RTL

- Sequencer for the 1-to-8 demux (inputs w, sel[2:0]; outputs y[7:0]).
- Steps sel through a programmable set of enabled channels and holds each one for a programmable dwell time.
- Drives w high while a channel is being served.
- Supports one-shot and continuous (round-robin) scans and replaces manual sel stepping in the lab design.

---
 rtl/demux18_scan_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/demux18_scan_ctrl.sv
// demux18_scan_ctrl: scan sequencer for the 1-to-8 demux.
// Walks o_sel through the enabled channels of a latched mask. Each channel is held for a
// programmable dwell. o_w stays high while any channel is served. Supports one-shot and
// continuous (round-robin) scans.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst    asynchronous active-high reset
//   i_start  begin a scan (sampled only in idle)
//   i_stop   abort the scan in progress (wins over i_start in idle)
//   i_mode   0 = one-shot, 1 = continuous; latched at start
//   i_mask   channel enables, bit i = channel i; latched at start
//   i_dwell  cycles per channel (0 treated as 1); latched at start
//   o_sel    demux select (registered)
//   o_w      demux strobe, high while a channel is served (registered)
//   o_busy   high while scanning
//   o_done   one-cycle pulse at end of one-shot scan or on start with empty mask
//   o_wrap   one-cycle pulse when a continuous scan returns to the lowest channel
module demux18_scan_ctrl #(
  parameter int unsigned DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic          i_mode,
  input  logic [7:0]    i_mask,
  input  logic [DW-1:0] i_dwell,
  output logic [2:0]    o_sel,
  output logic          o_w,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_wrap
);

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_mask;
  logic [DW-1:0] r_reload;   // d_eff - 1, so a dwell of 2^DW-1 fits without overflow
  logic          r_mode;
  logic [DW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_sel, w_sel_nxt;
  logic          r_w, r_busy, r_done, r_wrap;
  logic          w_wrap_nxt, w_latch;

  logic [DW-1:0] w_in_reload;
  logic [2:0]    w_in_low, w_lat_low, w_up_idx;
  logic          w_up_found;

  assign w_in_reload = (i_dwell == '0) ? '0 : i_dwell - DW'(1);

  // Channel search, purely combinational so consecutive channels run back-to-back.
  always_comb begin
    w_in_low   = '0;
    w_lat_low  = '0;
    w_up_idx   = '0;
    w_up_found = 1'b0;
    // Descending scans: the last hit is the lowest / nearest qualifying bit.
    for (int i = 7; i >= 0; i--) begin
      if (i_mask[i]) w_in_low = 3'(i);
      if (r_mask[i]) w_lat_low = 3'(i);
      if (r_mask[i] && (i > int'(r_sel))) begin
        w_up_found = 1'b1;
        w_up_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_wrap_nxt  = 1'b0;
    w_latch     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start && !i_stop) begin
          if (i_mask != 8'h00) begin
            w_state_nxt = StActive;
            w_sel_nxt   = w_in_low;
            w_cnt_nxt   = w_in_reload;
            w_latch     = 1'b1;
          end else begin
            w_state_nxt = StDone;
          end
        end
      end
      StActive: begin
        if (i_stop) begin
          w_state_nxt = StIdle;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - DW'(1);
        end else if (w_up_found) begin
          w_sel_nxt = w_up_idx;
          w_cnt_nxt = r_reload;
        end else if (r_mode) begin
          w_sel_nxt  = w_lat_low;
          w_cnt_nxt  = r_reload;
          w_wrap_nxt = 1'b1;
        end else begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_mask   <= '0;
      r_reload <= '0;
      r_mode   <= 1'b0;
      r_cnt    <= '0;
      r_sel    <= '0;
      r_w      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
      r_w     <= (w_state_nxt == StActive);
      r_busy  <= (w_state_nxt == StActive);
      r_done  <= (w_state_nxt == StDone);
      r_wrap  <= w_wrap_nxt;
      if (w_latch) begin
        r_mask   <= i_mask;
        r_reload <= w_in_reload;
        r_mode   <= i_mode;
      end
    end
  end

  assign o_sel  = r_sel;
  assign o_w    = r_w;
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_wrap = r_wrap;

endmodule
